// File: rtl/ext_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer on the D->E boundary.
// Optional stall counter output enabled by defining EXT_PIPE_STALL_CNT_EN.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef EXT_PIPE_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic [1:0]        out_op
);

  localparam logic [1:0] OP_ZERO = 2'd0;
  localparam logic [1:0] OP_SIGN = 2'd1;
  localparam logic [1:0] OP_LUI  = 2'd2;

  generate
    if (DATA_W < IMM_W + 2) begin : g_bad_width
      $error("ext_pipe: DATA_W must be at least IMM_W+2");
    end
  endgenerate

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic [1:0]        m_op, s_op;
  logic [DATA_W-1:0] sext, ext;
  logic              accept, pop;

  // Every op code yields a fully defined result; BROFS reuses the sign extension.
  always_comb begin
    sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    ext  = '0;
    case (in_op)
      OP_ZERO: ext = {{(DATA_W-IMM_W){1'b0}}, in_imm};
      OP_SIGN: ext = sext;
      OP_LUI:  ext = {in_imm, {(DATA_W-IMM_W){1'b0}}};
      default: ext = {sext[DATA_W-3:0], 2'b00};
    endcase
  end

  assign in_ready  = !s_valid;
  assign accept    = in_valid && !s_valid;
  assign pop       = m_valid && out_ready;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_op    = m_op;

  // Skid content is always older than any new accept, so it refills main first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
      m_op    <= '0;
      s_op    <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (pop && !accept) begin
      if (s_valid) begin
        m_data  <= s_data;
        m_op    <= s_op;
        s_valid <= 1'b0;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept && !pop) begin
      if (!m_valid) begin
        m_data  <= ext;
        m_op    <= in_op;
        m_valid <= 1'b1;
      end else begin
        s_data  <= ext;
        s_op    <= in_op;
        s_valid <= 1'b1;
      end
    end else if (accept && pop) begin
      m_data <= ext;
      m_op   <= in_op;
    end
  end

`ifdef EXT_PIPE_STALL_CNT_EN
  // Counts upstream stall cycles; only reset clears it, it wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (in_valid && !in_ready)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard testbench for ext_pipe: expected results are queued on accept and
// compared on pop; occupancy of the queue predicts in_ready/out_valid.
module tb_ext_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_op;
`ifdef EXT_PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt;
  int          stallModel = 0;
`endif

  int checks   = 0;
  int failures = 0;
  logic [33:0] sb[$];

  ext_pipe #(.IMM_W(16), .DATA_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_imm(in_imm),
    .in_op(in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
`ifdef EXT_PIPE_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .out_op(out_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelExt(input logic [15:0] imm, input logic [1:0] op);
    case (op)
      2'd0:    return {16'h0000, imm};
      2'd1:    return {{16{imm[15]}}, imm};
      2'd2:    return {imm, 16'h0000};
      default: return {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

  // One cycle: drive at negedge, check registered outputs, update the model for the next edge.
  task automatic applyStimulus(input logic v, input logic [15:0] imm, input logic [1:0] op,
                               input logic ordy, input logic fl);
    logic [33:0] e;
    logic        acc, pp;
    @(negedge clk);
    in_valid  = v;
    in_imm    = imm;
    in_op     = op;
    out_ready = ordy;
    flush     = fl;
    #1;
    checkOutput("out_valid", out_valid, sb.size() > 0);
    checkOutput("in_ready", in_ready, sb.size() < 2);
`ifdef EXT_PIPE_STALL_CNT_EN
    checkOutput("stall_cnt", stall_cnt, stallModel);
    if (v && sb.size() == 2) stallModel++;
`endif
    acc = v && (sb.size() < 2);
    pp  = (sb.size() > 0) && ordy;
    if (fl) begin
      sb.delete();
    end else begin
      if (pp) begin
        e = sb.pop_front();
        checkOutput("out_data", out_data, e[31:0]);
        checkOutput("out_op", out_op, e[33:32]);
      end
      if (acc) sb.push_back({op, modelExt(imm, op)});
    end
  endtask

  task automatic asyncReset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_out_op", out_op, 2'd0);
`ifdef EXT_PIPE_STALL_CNT_EN
    checkOutput("rst_stall_cnt", stall_cnt, 32'h0);
    stallModel = 0;
`endif
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_op     = '0;
    out_ready = 1'b0;
    #1;
    checkOutput("init_out_valid", out_valid, 1'b0);
    checkOutput("init_in_ready", in_ready, 1'b1);
    checkOutput("init_out_data", out_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] all four op codes, back to back");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h8004, 2'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);

    $display("[TB] backpressure fills main and skid");
    applyStimulus(1'b1, 16'h0001, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h7FFF, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h1234, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);

    $display("[TB] simultaneous accept and pop");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 16'(16'h0100 + i), 2'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);

    $display("[TB] flush while full");
    applyStimulus(1'b1, 16'hAAAA, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBBBB, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hDEAD, 2'd3, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h0042, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);

    $display("[TB] asynchronous reset while full");
    applyStimulus(1'b1, 16'hC001, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hC002, 2'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    asyncReset();
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b1, 1'b0);

`ifdef EXT_PIPE_STALL_CNT_EN
    $display("[TB] stall counter");
    applyStimulus(1'b1, 16'h1111, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2222, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h5555, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0);
    checkOutput("stall_five", stall_cnt, 32'd5);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 2'd0, 1'b0, 1'b0);
    checkOutput("stall_after_flush", stall_cnt, 32'd5);
    asyncReset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
